// File: rtl/wb_regfile.sv
// wb_regfile: 32 x DATA_WIDTH register file with a per-register in-flight
// scoreboard. It consumes the writeback stream and serves decode operand
// reads. It raises Stall while an operand's producer has not yet written back.
// Optional feature macro: WB_BYPASS_EN. When defined, a same-cycle writeback
// is forwarded to the read ports, and the final retiring writeback releases
// the operand stall in the same cycle.
//
// Issue handshake: IssueValid is "valid" and !Stall is "ready". An issue to
// IssueRegister is accepted on a rising Clock edge where both are high and
// IssueRegister != 0. Decode must hold IssueValid/IssueRegister steady until
// that happens. Accepted issues to register 0 are ignored.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  IssueValid,
  input  logic [4:0]            IssueRegister,
  input  logic                  Flush,
  output logic                  Stall,
  output logic [5:0]            PendingCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs_q [32];
  logic [DATA_WIDTH-1:0] regs_d [32];
  logic [CNT_WIDTH-1:0]  cnt_q  [32];
  logic [CNT_WIDTH-1:0]  cnt_d  [32];
  logic [5:0]            pending_q, pending_d;

  logic wb_hit;
  logic issue_acc;
  logic stall_rs1, stall_rs2, stall_sat;

  assign wb_hit       = RegWrite && (WriteRegister != 5'd0);
  assign PendingCount = pending_q;

  // Operand read and stall generation; the optional bypass overrides the stored value.
  always_comb begin
    ReadData1 = (ReadRegister1 == 5'd0) ? '0 : regs_q[ReadRegister1];
    ReadData2 = (ReadRegister2 == 5'd0) ? '0 : regs_q[ReadRegister2];
    stall_rs1 = (cnt_q[ReadRegister1] != '0);
    stall_rs2 = (cnt_q[ReadRegister2] != '0);
`ifdef WB_BYPASS_EN
    if (wb_hit && (WriteRegister == ReadRegister1)) begin
      ReadData1 = WriteData;
      if (cnt_q[ReadRegister1] == CNT_ONE) stall_rs1 = 1'b0;
    end
    if (wb_hit && (WriteRegister == ReadRegister2)) begin
      ReadData2 = WriteData;
      if (cnt_q[ReadRegister2] == CNT_ONE) stall_rs2 = 1'b0;
    end
`else
    // Without bypass the new value appears next cycle and the stall holds until then.
`endif
    stall_sat = IssueValid && (cnt_q[IssueRegister] == CNT_SAT);
    Stall     = stall_rs1 || stall_rs2 || stall_sat;
    issue_acc = IssueValid && !Stall && (IssueRegister != 5'd0);
  end

  // Next register contents, in-flight counters and the population count of busy registers.
  always_comb begin
    pending_d = 6'd0;
    for (int i = 0; i < 32; i++) begin
      logic inc;
      logic dec;
      inc       = issue_acc && (IssueRegister == 5'(i));
      dec       = wb_hit && (WriteRegister == 5'(i));
      regs_d[i] = dec ? WriteData : regs_q[i];
      cnt_d[i]  = cnt_q[i];
      if (Flush) begin
        cnt_d[i] = '0;
      end else if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    // Register 0 is hardwired: never written, never busy.
    regs_d[0] = '0;
    cnt_d[0]  = '0;
    for (int i = 1; i < 32; i++) begin
      if (cnt_d[i] != '0) pending_d = pending_d + 6'd1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      regs_q    <= '{default: '0};
      cnt_q     <= '{default: '0};
      pending_q <= 6'd0;
    end else begin
      regs_q    <= regs_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors for wb_regfile. Build with +define+WB_BYPASS_EN
// to select the bypass expectations in the writeback-cycle checks.
module tb_wb_regfile;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         reg_write;
  logic [4:0]   write_register;
  logic [W-1:0] write_data;
  logic [4:0]   read_register1, read_register2;
  logic [W-1:0] read_data1, read_data2;
  logic         issue_valid;
  logic [4:0]   issue_register;
  logic         flush;
  logic         stall;
  logic [5:0]   pending_count;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  wb_regfile #(.DATA_WIDTH(W), .CNT_WIDTH(2)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .RegWrite     (reg_write),
    .WriteRegister(write_register),
    .WriteData    (write_data),
    .ReadRegister1(read_register1),
    .ReadRegister2(read_register2),
    .ReadData1    (read_data1),
    .ReadData2    (read_data2),
    .IssueValid   (issue_valid),
    .IssueRegister(issue_register),
    .Flush        (flush),
    .Stall        (stall),
    .PendingCount (pending_count)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single checking task: counts every comparison and reports mismatches.
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write      = 1'b0;
    write_register = 5'd0;
    write_data     = '0;
    issue_valid    = 1'b0;
    issue_register = 5'd0;
    flush          = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] idx, input logic [W-1:0] data);
    reg_write      = 1'b1;
    write_register = idx;
    write_data     = data;
    tick();
    reg_write      = 1'b0;
    write_register = 5'd0;
    write_data     = '0;
    #1;
  endtask

  task automatic issue(input logic [4:0] idx);
    issue_valid    = 1'b1;
    issue_register = idx;
    tick();
    issue_valid    = 1'b0;
    issue_register = 5'd0;
    #1;
  endtask

  task automatic set_reads(input logic [4:0] r1, input logic [4:0] r2);
    read_register1 = r1;
    read_register2 = r2;
    #1;
  endtask

  initial begin
    idle();
    read_register1 = 5'd0;
    read_register2 = 5'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_rd1", read_data1, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_pending", {26'b0, pending_count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Register 0 ignores writes, including for the counters
    wb_write(5'd0, 32'hDEADBEEF);
    set_reads(5'd0, 5'd0);
    check("r0_read", read_data1, 32'h0);
    check("r0_pending", {26'b0, pending_count}, 32'h0);

    // Mid-cycle reset clears data immediately
    wb_write(5'd5, 32'h0000_0055);
    set_reads(5'd5, 5'd0);
    check("r5_written", read_data1, 32'h0000_0055);
    issue(5'd5);
    check("r5_pending", {26'b0, pending_count}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("r5_after_reset", read_data1, 32'h0);
    check("pending_after_reset", {26'b0, pending_count}, 32'h0);
    check("stall_after_reset", {31'b0, stall}, 32'h0);
    rst = 1'b0;
    tick();

    // Basic dependency on reg 7
    set_reads(5'd0, 5'd0);
    issue(5'd7);
    set_reads(5'd7, 5'd0);
    check("dep7_stall", {31'b0, stall}, 32'h1);
    check("dep7_pending", {26'b0, pending_count}, 32'h1);
    reg_write      = 1'b1;
    write_register = 5'd7;
    write_data     = 32'h12345678;
    #1;
`ifdef WB_BYPASS_EN
    check("dep7_wb_cycle_rd1", read_data1, 32'h12345678);
    check("dep7_wb_cycle_stall", {31'b0, stall}, 32'h0);
`else
    check("dep7_wb_cycle_rd1", read_data1, 32'h0);
    check("dep7_wb_cycle_stall", {31'b0, stall}, 32'h1);
`endif
    tick();
    idle();
    #1;
    check("dep7_after_rd1", read_data1, 32'h12345678);
    check("dep7_after_stall", {31'b0, stall}, 32'h0);
    check("dep7_after_pending", {26'b0, pending_count}, 32'h0);

    // Three issues to reg 3 saturate the counter; a fourth is refused
    set_reads(5'd0, 5'd0);
    issue(5'd3);
    issue(5'd3);
    issue_valid    = 1'b1;
    issue_register = 5'd3;
    #1;
    check("sat_third_accepted", {31'b0, stall}, 32'h0);
    tick();
    check("sat_fourth_stall", {31'b0, stall}, 32'h1);
    tick();
    idle();
    #1;
    check("sat_pending", {26'b0, pending_count}, 32'h1);
    set_reads(5'd3, 5'd0);
    wb_write(5'd3, 32'h0000_0301);
    check("sat_wb1_stall", {31'b0, stall}, 32'h1);
    wb_write(5'd3, 32'h0000_0302);
    check("sat_wb2_stall", {31'b0, stall}, 32'h1);
    wb_write(5'd3, 32'h0000_0303);
    check("sat_wb3_stall", {31'b0, stall}, 32'h0);
    check("sat_wb3_rd1", read_data1, 32'h0000_0303);
    check("sat_wb3_pending", {26'b0, pending_count}, 32'h0);

    // Simultaneous issue and writeback on reg 9 keeps cnt at 1
    set_reads(5'd0, 5'd0);
    issue(5'd9);
    issue_valid    = 1'b1;
    issue_register = 5'd9;
    reg_write      = 1'b1;
    write_register = 5'd9;
    write_data     = 32'h0000_0909;
    tick();
    idle();
    set_reads(5'd0, 5'd9);
    check("simul9_stall", {31'b0, stall}, 32'h1);
    check("simul9_pending", {26'b0, pending_count}, 32'h1);
    wb_write(5'd9, 32'h0000_0999);
    check("simul9_retired", {31'b0, stall}, 32'h0);
    check("simul9_rd2", read_data2, 32'h0000_0999);

    // Flush together with an issue to reg 8
    set_reads(5'd0, 5'd0);
    issue(5'd2);
    issue(5'd4);
    issue(5'd6);
    check("flush_pre_pending", {26'b0, pending_count}, 32'h3);
    flush          = 1'b1;
    issue_valid    = 1'b1;
    issue_register = 5'd8;
    tick();
    idle();
    #1;
    check("flush_pending", {26'b0, pending_count}, 32'h0);
    set_reads(5'd2, 5'd4);
    check("flush_stall_2_4", {31'b0, stall}, 32'h0);
    set_reads(5'd6, 5'd8);
    check("flush_stall_6_8", {31'b0, stall}, 32'h0);

    // Underflow: data stored, counters untouched
    set_reads(5'd0, 5'd0);
    issue(5'd12);
    wb_write(5'd11, 32'hA5A5A5A5);
    set_reads(5'd11, 5'd0);
    check("uflow_rd1", read_data1, 32'hA5A5A5A5);
    check("uflow_stall", {31'b0, stall}, 32'h0);
    check("uflow_pending", {26'b0, pending_count}, 32'h1);
    wb_write(5'd12, 32'h0000_0C0C);
    check("uflow_r12_retired", {26'b0, pending_count}, 32'h0);

    // Scoreboard sweep through ReadData2
    for (int i = 20; i < 24; i++) begin
      logic [W-1:0] v;
      v = $urandom_range(32'h7FFF_FFFF, 1);
      wb_write(5'(i), v);
      exp_q.push_back(v);
    end
    for (int i = 20; i < 24; i++) begin
      logic [W-1:0] e;
      set_reads(5'd0, 5'(i));
      e = exp_q.pop_front();
      check($sformatf("sweep_r%0d", i), read_data2, e);
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
